if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register and feeds its Instruction_in and PC_in inputs.
- Owns the program counter and drives a request/ready instruction-memory port that may insert wait states.
- Presents one instruction plus its PC+4 per accepted fetch; emits the NOP encoding on bubbles.
- Honours hazard stalls and branch/jump redirects, including a redirect that arrives while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
NOP_INSTR, 32'hE000_0000, bubble encoding (opcode 111000, control-unit default)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  from hazard detection unit; 1 = downstream cannot accept, hold PC
branch_taken  input  1  branch resolved taken in ID; redirect to branch_target
branch_target  input  32  branch destination address
jump  input  1  unconditional jump decoded in ID; redirect to jump_target
jump_target  input  32  jump destination address
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  fetch address; word aligned, equals pc
imem_ready  input  1  memory accepts the request and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
Instruction_out  output  32  to IF/ID Instruction_in
PC_out  output  32  to IF/ID PC_in (fetch address + 4)
valid_out  output  1  1 = Instruction_out is a real instruction, 0 = bubble

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC, state = IDLE, buffer empty, discard flag clear.
  - imem_req = 0, Instruction_out = NOP_INSTR, PC_out = 32'h0, valid_out = 0.
- Memory handshake:
  - imem_req/imem_addr stay stable until a rising edge with imem_req=1 and imem_ready=1.
  - A transaction completes only at that edge. Data is valid in the same cycle as ready.
  - Zero-wait memory (ready tied high) yields one instruction per cycle.
- FSM states:
  - IDLE: no outstanding request.
  - BUSY: request outstanding, response is wanted.
  - DISCARD: request outstanding, response must be dropped.
  - BUFFERED: one-entry buffer holds an instruction captured during a stall.
- IDLE:
  - imem_req = !stall. Go to BUSY if the request is not completed this cycle.
  - If ready arrives in the same cycle, stay in the request-issuing flow.
- BUSY:
  - On ready with stall=0: Instruction_out = imem_rdata, PC_out = pc+4, valid_out = 1 (combinational, zero latency to IF/ID); pc <= pc+4; next request issued next cycle.
  - On ready with stall=1: capture rdata and pc+4 into the buffer; pc <= pc+4; go to BUFFERED; imem_req = 0 while buffered.
- BUFFERED:
  - Outputs = buffer contents with valid_out = 1 when stall=0; otherwise NOP_INSTR with valid_out = 0.
  - When stall=0 the buffer drains that cycle and the FSM returns to IDLE/issue.
- Without a completed ready or buffer drain: Instruction_out = NOP_INSTR, valid_out = 0, PC_out = pc+4.
- Redirect (branch_taken or jump):
  - Priority: branch_taken > jump > stall > sequential.
  - Redirect overrides stall and clears the buffer.
  - If no request is outstanding: pc <= target and go to IDLE. The current-cycle output is forced to NOP_INSTR / valid_out = 0.
  - If a request is outstanding without ready this cycle: latch the target into redirect_pc and go to DISCARD. The request is not withdrawn; address is held.
  - If ready arrives in the redirect cycle: drop the data (output NOP) and set pc <= target.
- DISCARD:
  - On ready: drop rdata, output NOP/valid 0, pc <= redirect_pc, go to IDLE.
  - A further redirect while in DISCARD overwrites redirect_pc (newest wins).
- Arithmetic: pc+4 is a 32-bit wrap-around add; 32'hFFFF_FFFC + 4 = 32'h0. Targets are used unmodified; the low 2 bits are not checked.
- Reset asserted mid-transaction abandons the request immediately; memory must tolerate a dropped req.

Decomposition:
- Shared package holds:
  - NOP_INSTR constant
  - FSM state encoding (2-bit: IDLE, BUSY, DISCARD, BUFFERED)
  - PC_INCR = 4
- One natural sub-module: if_fetch_buffer (one-entry instr/pc holding register with valid bit, load/drain/clear).
- PC register and FSM stay in the top module.

Test Plan:
- Reset release, imem_ready tied 1, rdata = addr-derived words → addresses 0,4,8,…; PC_out 4,8,12,…; valid_out = 1 every cycle from the first post-reset cycle.
- Memory with 2 wait states → imem_addr held stable 3 cycles; two NOP bubbles, then one valid instruction per 3 cycles.
- stall=1 for 3 cycles while a response arrives → instruction buffered, imem_req = 0, outputs NOP; on stall=0 the buffered word appears once with the correct PC_out and is not duplicated.
- branch_taken=1, branch_target = 32'h100, during an outstanding waited request → that response is dropped (valid_out = 0); next imem_addr = 32'h100.
- branch_taken and jump together (targets 32'h200 / 32'h300) with stall=1 → pc becomes 32'h200; stall does not block the redirect.
- RESET_PC = 32'hFFFF_FFFC → the second fetch address is 32'h0000_0000; reset asserted mid-wait → outputs return to reset values immediately.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   IF_NOP_INSTR  : bubble encoding presented to IF/ID when no instruction is delivered
//   PC_INCR       : sequential fetch stride in bytes
//   fetch_state_e : fetch FSM state encoding
package if_fetch_unit_pkg;

  localparam logic [31:0] IF_NOP_INSTR = 32'hE000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,  // no outstanding request
    StBusy     = 2'd1,  // request outstanding, response wanted
    StDiscard  = 2'd2,  // request outstanding, response will be dropped
    StBuffered = 2'd3   // buffer holds an instruction captured under stall
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register for an instruction fetched while the pipeline is stalled.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   load               : capture instr_in/pc_in and mark the entry valid
//   drain              : entry consumed downstream, mark invalid
//   clear              : flush the entry (redirect); wins over load and drain
//   instr_in, pc_in    : word and its PC+4 to capture
//   instr, pc, valid   : current contents
module if_fetch_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= IF_NOP_INSTR;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
      valid_q <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, drives a req/ready instruction-memory port and hands one instruction plus
// its PC+4 to IF/ID per completed fetch, or the NOP encoding on bubbles.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   stall                        : downstream cannot accept; hold the PC
//   branch_taken, branch_target  : taken-branch redirect (highest priority)
//   jump, jump_target            : jump redirect
//   imem_req, imem_addr          : memory request and word address (= pc)
//   imem_ready, imem_rdata       : memory accept and same-cycle read data
//   Instruction_out, PC_out      : to IF/ID Instruction_in / PC_in
//   valid_out                    : 1 = real instruction, 0 = bubble
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out,
  output logic        valid_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic [31:0]  redirect_target;

  logic         buf_load, buf_drain, buf_clear;
  logic [31:0]  buf_instr, buf_pc;
  logic         buf_valid;

  assign pc_plus4        = pc_q + PC_INCR;
  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign imem_addr       = pc_q;
  assign buf_clear       = redirect;

  if_fetch_buffer u_buffer (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_plus4),
    .instr    (buf_instr),
    .pc       (buf_pc),
    .valid    (buf_valid)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redirect_pc_d   = redirect_pc_q;
    buf_load        = 1'b0;
    buf_drain       = 1'b0;
    imem_req        = 1'b0;
    Instruction_out = NOP_INSTR;
    PC_out          = pc_plus4;
    valid_out       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // No point fetching the old pc when a redirect is already known.
        imem_req = !stall && !redirect;
        if (redirect) begin
          pc_d = redirect_target;
        end else if (imem_req) begin
          if (imem_ready) begin
            Instruction_out = imem_rdata;
            valid_out       = 1'b1;
            pc_d            = pc_plus4;
          end else begin
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        // Request must stay up with a stable address until accepted.
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ready) begin
            pc_d    = redirect_target;
            state_d = StIdle;
          end else begin
            redirect_pc_d = redirect_target;
            state_d       = StDiscard;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (stall) begin
            buf_load = 1'b1;
            state_d  = StBuffered;
          end else begin
            Instruction_out = imem_rdata;
            valid_out       = 1'b1;
            state_d         = StIdle;
          end
        end
      end

      StDiscard: begin
        imem_req = 1'b1;
        // Newest redirect wins, even in the cycle the stale response lands.
        if (imem_ready) begin
          pc_d    = redirect ? redirect_target : redirect_pc_q;
          state_d = StIdle;
        end else if (redirect) begin
          redirect_pc_d = redirect_target;
        end
      end

      StBuffered: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = StIdle;
        end else if (!stall) begin
          Instruction_out = buf_instr;
          PC_out          = buf_pc;
          valid_out       = buf_valid;
          buf_drain       = 1'b1;
          state_d         = StIdle;
        end
      end
    endcase

    // Outputs take their reset values as soon as reset asserts, not at the next edge.
    if (!reset) begin
      imem_req        = 1'b0;
      Instruction_out = NOP_INSTR;
      PC_out          = 32'h0;
      valid_out       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
  logic [31:0] instr_out, instr_out2, pc_out, pc_out2;
  logic        valid_out, valid_out2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address so every word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .Instruction_out (instr_out),
    .PC_out          (pc_out),
    .valid_out       (valid_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .reset           (reset2),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .imem_req        (imem_req2),
    .imem_addr       (imem_addr2),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata2),
    .Instruction_out (instr_out2),
    .PC_out          (pc_out2),
    .valid_out       (valid_out2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase: architectural next-instruction address.
  logic [31:0] exp_addr;
  logic        prev_req, prev_ready;
  logic [31:0] prev_addr;
  int          delivered;

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    branch_target = 32'h0; jump_target = 32'h0;
    to_next();

    // Reset values
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_valid", {31'b0, valid_out}, 32'h0);

    // Zero-wait memory: one instruction per cycle from the first cycle after release
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      check("zw_addr", imem_addr, 32'(4 * i));
      check("zw_pc_out", pc_out, 32'(4 * i + 4));
      check("zw_valid", {31'b0, valid_out}, 32'h1);
      check("zw_instr", instr_out, mem_word(32'(4 * i)));
      to_next();
    end

    // Two wait states at address 20
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_neg();
      check("ws_req", {31'b0, imem_req}, 32'h1);
      check("ws_addr", imem_addr, 32'd20);
      check("ws_bubble", {31'b0, valid_out}, 32'h0);
      check("ws_nop", instr_out, NOP);
      to_next();
    end
    imem_ready = 1'b1;
    to_neg();
    check("ws_addr3", imem_addr, 32'd20);
    check("ws_valid", {31'b0, valid_out}, 32'h1);
    check("ws_instr", instr_out, mem_word(32'd20));
    check("ws_pc_out", pc_out, 32'd24);
    to_next();

    // Stall while the response for 24 arrives: buffered, then delivered once
    imem_ready = 1'b0;
    to_neg(); check("st_issue", imem_addr, 32'd24); to_next();
    stall = 1'b1; imem_ready = 1'b1;
    to_neg(); check("st_cap_bubble", {31'b0, valid_out}, 32'h0); to_next();
    for (int i = 0; i < 2; i++) begin
      to_neg();
      check("st_req_low", {31'b0, imem_req}, 32'h0);
      check("st_nop", instr_out, NOP);
      check("st_bubble", {31'b0, valid_out}, 32'h0);
      to_next();
    end
    stall = 1'b0;
    to_neg();
    check("st_drain_valid", {31'b0, valid_out}, 32'h1);
    check("st_drain_instr", instr_out, mem_word(32'd24));
    check("st_drain_pc", pc_out, 32'd28);
    to_next();
    to_neg();
    check("st_next_addr", imem_addr, 32'd28);
    check("st_next_instr", instr_out, mem_word(32'd28));
    check("st_next_pc", pc_out, 32'd32);
    to_next();

    // Branch to 0x100 while a waited request for 32 is outstanding
    imem_ready = 1'b0;
    to_neg(); check("br_issue", imem_addr, 32'd32); to_next();
    branch_taken = 1'b1; branch_target = 32'h100;
    to_neg(); check("br_cycle_bubble", {31'b0, valid_out}, 32'h0); to_next();
    branch_taken = 1'b0; branch_target = 32'h0;
    to_neg();
    check("br_hold_req", {31'b0, imem_req}, 32'h1);
    check("br_hold_addr", imem_addr, 32'd32);
    to_next();
    imem_ready = 1'b1;
    to_neg();
    check("br_drop", {31'b0, valid_out}, 32'h0);
    check("br_drop_nop", instr_out, NOP);
    to_next();
    to_neg();
    check("br_target_addr", imem_addr, 32'h100);
    check("br_target_instr", instr_out, mem_word(32'h100));
    to_next();

    // Branch and jump together under stall: branch wins, stall does not block
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    to_neg();
    check("bj_bubble", {31'b0, valid_out}, 32'h0);
    to_next();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    to_neg();
    check("bj_addr", imem_addr, 32'h200);
    check("bj_pc_out", pc_out, 32'h204);
    check("bj_valid", {31'b0, valid_out}, 32'h1);
    to_next();

    // Reset asserted mid-wait
    imem_ready = 1'b0;
    to_neg(); check("rw_req", {31'b0, imem_req}, 32'h1); to_next();
    reset = 1'b0;
    #1;
    check("rw_req_low", {31'b0, imem_req}, 32'h0);
    check("rw_valid", {31'b0, valid_out}, 32'h0);
    check("rw_pc_out", pc_out, 32'h0);
    check("rw_instr", instr_out, NOP);
    check("rw_addr", imem_addr, 32'h0);

    // RESET_PC at the top of memory: second fetch wraps to 0
    to_next();
    imem_ready = 1'b1; reset2 = 1'b1;
    to_neg();
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    check("wrap_pc_out0", pc_out2, 32'h0);
    check("wrap_valid0", {31'b0, valid_out2}, 32'h1);
    to_next();
    to_neg();
    check("wrap_addr1", imem_addr2, 32'h0);
    check("wrap_pc_out1", pc_out2, 32'h4);
    to_next();

    // Random phase against a stream-level model: delivered words must follow program order,
    // redirects restart the order at the target, and requests hold until accepted.
    reset = 1'b1;
    exp_addr = 32'h0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0; delivered = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall         = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 9) < 6);
      branch_taken  = ($urandom_range(0, 11) == 0);
      jump          = ($urandom_range(0, 11) == 0);
      branch_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      jump_target   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      to_neg();
      if (prev_req && !prev_ready) begin
        check("rnd_req_held", {31'b0, imem_req}, 32'h1);
        check("rnd_addr_held", imem_addr, prev_addr);
      end
      if (branch_taken || jump) begin
        check("rnd_redirect_bubble", {31'b0, valid_out}, 32'h0);
        exp_addr = branch_taken ? branch_target : jump_target;
      end else if (valid_out) begin
        check("rnd_no_valid_in_stall", {31'b0, stall}, 32'h0);
        check("rnd_instr", instr_out, mem_word(exp_addr));
        check("rnd_pc_out", pc_out, exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd4;
        delivered++;
      end else begin
        check("rnd_bubble_nop", instr_out, NOP);
      end
      prev_req = imem_req; prev_ready = imem_ready; prev_addr = imem_addr;
      to_next();
    end
    check("rnd_progress", {31'b0, delivered >= 40}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
